instruction_fetch_unit: RTL

Front end of the RV32I pipeline: owns the program counter, issues word fetches to instruction memory, buffers returned instructions, and delivers them in order to decode. Consumes the redirect outputs of the branch/jump unit (`taken`, `flush`, target address). On a redirect it discards every fetch already in flight and restarts at the target.

---
 rtl/instruction_fetch_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch front end. This block owns the fetch PC and issues word
// fetches to instruction memory. It keeps a small FIFO of returned
// instructions and hands them to decode in program order. A redirect from
// the branch/jump unit throws away everything in flight and restarts fetch
// at the new target.
module instruction_fetch_unit #(
  parameter int                 NB_WORD  = 32,
  parameter int                 NB_ADDR  = 32,
  parameter logic [NB_ADDR-1:0] RESET_PC = '0,
  parameter int                 DEPTH    = 2
) (
  input  logic               i_clock,
  input  logic               i_reset,
  output logic               o_imem_req,
  output logic [NB_ADDR-1:0] o_imem_addr,
  input  logic               i_imem_ready,
  input  logic               i_imem_rvalid,
  input  logic [NB_WORD-1:0] i_imem_rdata,
  input  logic               i_branch_taken,
  input  logic               i_flush,
  input  logic [NB_ADDR-1:0] i_branch_addr,
  output logic               o_valid,
  output logic [NB_WORD-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_pc,
  input  logic               i_ready,
  output logic               o_misaligned
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0]      DEPTH_C    = CW'(DEPTH);
  localparam logic [PW-1:0]      LAST_C     = PW'(DEPTH - 1);
  localparam logic [NB_ADDR-1:0] RESET_PC_A = {RESET_PC[NB_ADDR-1:2], 2'b00};

  typedef enum logic {BOOT, RUN} state_e;

  state_e             state_q, state_d;
  logic [NB_ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic [NB_ADDR-1:0] deliver_pc_q, deliver_pc_d;
  logic [CW-1:0]      outstanding_q, outstanding_d;
  logic [CW-1:0]      drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]      count_q, count_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic               misaligned_q, misaligned_d;
  logic [NB_WORD-1:0] fifo_q [DEPTH];

  logic               redir, accept, rsp, push, pop;
  logic               fifo_empty, fifo_full;
  logic [NB_ADDR-1:0] target;
  logic [CW:0]        credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  assign redir      = i_flush | i_branch_taken;
  assign target     = {i_branch_addr[NB_ADDR-1:2], 2'b00};
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);

  // One credit per in-flight request or buffered word. This is what keeps
  // the FIFO from overflowing, since every request has a slot reserved.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
  assign o_imem_req  = (state_q == RUN) & ~redir & (credit_used < {1'b0, DEPTH_C});
  assign o_imem_addr = fetch_pc_q;
  assign accept      = o_imem_req & i_imem_ready;

  // A response is kept only when nothing stale is still due and no redirect
  // is killing this cycle.
  assign rsp  = i_imem_rvalid;
  assign push = rsp & ~redir & (drop_cnt_q == '0);

  assign o_valid       = ~fifo_empty & ~redir;
  assign pop           = o_valid & i_ready;
  assign o_instruction = fifo_q[rd_ptr_q];
  assign o_pc          = deliver_pc_q;
  assign o_misaligned  = misaligned_q;

  // Next-state logic. A redirect overrides fetch, delivery and buffering.
  always_comb begin
    state_d       = RUN;  // BOOT lasts exactly one cycle
    fetch_pc_d    = fetch_pc_q;
    deliver_pc_d  = deliver_pc_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    misaligned_d  = 1'b0;
    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp);
    if (redir) begin
      fetch_pc_d   = target;
      deliver_pc_d = target;
      // The stale set is the live requests plus those already marked for
      // dropping. outstanding counts both groups, so the whole in-flight
      // total left after this cycle's response becomes the new drop count.
      drop_cnt_d   = outstanding_q - CW'(rsp);
      count_d      = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      misaligned_d = |i_branch_addr[1:0];
    end else begin
      if (accept)
        fetch_pc_d = fetch_pc_q + NB_ADDR'(4);
      if (pop) begin
        deliver_pc_d = deliver_pc_q + NB_ADDR'(4);
        rd_ptr_d     = ptr_inc(rd_ptr_q);
      end
      if (rsp && (drop_cnt_q != '0))
        drop_cnt_d = drop_cnt_q - 1'b1;
      if (push)
        wr_ptr_d = ptr_inc(wr_ptr_q);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State, PCs, counters and the misaligned pulse, with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC_A;
      deliver_pc_q  <= RESET_PC_A;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      deliver_pc_q  <= deliver_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      misaligned_q  <= misaligned_d;
    end
  end

  // FIFO storage. It needs no reset because the pointers and count define
  // which entries are valid.
  always_ff @(posedge i_clock) begin
    if (push)
      fifo_q[wr_ptr_q] <= i_imem_rdata;
  end

  // The credit rule makes a push into a full FIFO impossible.
  a_no_overflow: assert property (@(posedge i_clock) disable iff (i_reset)
    !(push && fifo_full));

  a_counters_bounded: assert property (@(posedge i_clock) disable iff (i_reset)
    (outstanding_q <= DEPTH_C) && (count_q <= DEPTH_C) && (drop_cnt_q <= DEPTH_C));

endmodule
